// File: rtl/m6809_uart_tx.sv
// m6809_uart_tx
//
// Memory-mapped 8N1 serial transmitter. It is the bus responder for the
// core6809 inside m6809_integration. The CPU queues bytes into a small
// transmit FIFO. A baud-rate state machine shifts each byte out LSB first
// on txd. An optional interrupt flags an empty FIFO.
//
// Register map (addr):
//   0 TXDATA  write pushes a byte into the FIFO; reads return 0
//   1 STATUS  read {ie, 3'b000, ovf, busy, empty, full}
//             write bit7 loads ie, bit3=1 clears ovf
//   2 DIVLO   divisor bits 7:0  (bit period = DIV+1 clk cycles)
//   3 DIVHI   divisor bits 15:8
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   sel        bus select from the address decoder
//   addr       register select
//   data_in    write data from the core
//   data_rw_n  1 = read, 0 = write
//   data_out   combinational read data, 0 when not selected
//   txd        serial output, idle high
//   irq        registered interrupt, ie & FIFO empty
module m6809_uart_tx #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    input  logic       data_rw_n,
    output logic [7:0] data_out,
    output logic       txd,
    output logic       irq
);

    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] ONE_COUNT  = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [7:0]      shift_q, shift_d;
    logic [15:0]     baud_q, baud_d;
    logic [15:0]     div_q, div_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            ovf_q, ovf_d;
    logic            ie_q, ie_d;
    logic            txd_q, txd_d;
    logic            irq_q, irq_d;

    logic            bus_wr;
    logic            wr_txdata;
    logic            wr_status;
    logic            fifo_empty;
    logic            fifo_full;
    logic            baud_done;
    logic            pop;
    logic            push;
    logic            busy;

    assign bus_wr     = sel & ~data_rw_n;
    assign wr_txdata  = bus_wr && (addr == 2'd0);
    assign wr_status  = bus_wr && (addr == 2'd1);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign baud_done  = (baud_q == 16'd0);
    assign busy       = (state_q != IDLE);

    // A pop happens whenever the shifter is ready for a new byte: sitting
    // idle, or at the last cycle of a stop bit so frames chain with no gap.
    assign pop = ~fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));

    // A full FIFO still accepts a byte when the same edge pops one.
    assign push = wr_txdata && (~fifo_full || pop);

    // Bus-side register updates: FIFO pointers and occupancy, overflow flag,
    // interrupt enable and the two halves of the baud divisor.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ie_d     = ie_q;
        div_d    = div_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase

        if (wr_status) begin
            ie_d = data_in[7];
            if (data_in[3]) begin
                ovf_d = 1'b0;
            end
        end
        if (wr_txdata && !push) begin
            ovf_d = 1'b1;
        end

        if (bus_wr && (addr == 2'd2)) begin
            div_d[7:0] = data_in;
        end
        if (bus_wr && (addr == 2'd3)) begin
            div_d[15:8] = data_in;
        end
    end

    // Transmit state machine. The baud counter runs from the divisor down to
    // zero and reloads from the live divisor at every bit boundary, so a
    // divisor change lands on the next bit rather than mid-bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;

        case (state_q)
            IDLE: begin
                bit_idx_d = 3'd0;
                if (pop) begin
                    shift_d = fifo_mem[rd_ptr_q];
                    baud_d  = div_q;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = div_q;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = div_q;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (pop) begin
                        shift_d = fifo_mem[rd_ptr_q];
                        baud_d  = div_q;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // txd is registered from the next state so the line has no decode
    // glitches; irq lags the ie & empty condition by one cycle.
    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        irq_d = ie_q & fifo_empty;
    end

    // State register with synchronous reset. Reset drops any queued bytes
    // by clearing the pointers and the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            shift_q   <= 8'h00;
            baud_q    <= 16'd0;
            div_q     <= DEFAULT_DIV;
            bit_idx_q <= 3'd0;
            ovf_q     <= 1'b0;
            ie_q      <= 1'b0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            ovf_q     <= ovf_d;
            ie_q      <= ie_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
        end
    end

    // FIFO storage needs no reset; only entries between the pointers are
    // ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data_in;
        end
    end

    // Read mux. Reads have no side effects and the bus sees zero whenever
    // this block is not selected.
    always_comb begin
        data_out = 8'h00;
        if (sel) begin
            case (addr)
                2'd1:    data_out = {ie_q, 3'b000, ovf_q, busy, fifo_empty, fifo_full};
                2'd2:    data_out = div_q[7:0];
                2'd3:    data_out = div_q[15:8];
                default: data_out = 8'h00;
            endcase
        end
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_m6809_uart_tx.sv
// tb_m6809_uart_tx
//
// Self-checking bench for m6809_uart_tx. Directed bus writes push the bytes
// expected on the wire into a scoreboard queue. A separate serial monitor
// watches txd, decodes each frame at the current bit period, and checks it
// against the head of that queue. Register reads, irq and timing points are
// checked inline against hand-computed values.
module tb_m6809_uart_tx;

    logic       clk;
    logic       reset;
    logic       sel;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic       data_rw_n;
    logic [7:0] data_out;
    logic       txd;
    logic       irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_wr_cyc;
    int bit_period;
    int frames_done = 0;

    logic [7:0] sb_q[$];
    int         start_q[$];

    m6809_uart_tx #(
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .addr     (addr),
        .data_in  (data_in),
        .data_rw_n(data_rw_n),
        .data_out (data_out),
        .txd      (txd),
        .irq      (irq)
    );

    // 10-unit clock and a free-running cycle counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something hangs well beyond the expected run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus write, taking effect at the next rising edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        sel       = 1'b1;
        addr      = a;
        data_in   = d;
        data_rw_n = 1'b0;
        @(posedge clk);
        #1;
        last_wr_cyc = cyc;
        sel         = 1'b0;
        data_rw_n   = 1'b1;
    endtask

    // Combinational read in the low half of the clock; no edge sees sel.
    task automatic readReg(input logic [1:0] a, output logic [7:0] v);
        @(negedge clk);
        sel       = 1'b1;
        addr      = a;
        data_rw_n = 1'b1;
        #1;
        v   = data_out;
        sel = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(name, frames_done, target);
    endtask

    // Serial monitor: on a falling txd it samples one full frame, checks
    // every cycle against the ideal waveform for the expected byte, and
    // decodes the byte from mid-bit samples. A reset inside a frame
    // abandons it without checking.
    int         mon_p;
    int         mon_start;
    int         mon_bit;
    logic [7:0] mon_exp;
    logic [7:0] mon_rx;
    logic       mon_lvl;
    bit         mon_have;
    bit         mon_shape;
    bit         mon_abort;

    always begin
        @(negedge clk);
        if (!reset && txd === 1'b0) begin
            mon_p     = bit_period;
            mon_start = cyc;
            mon_have  = (sb_q.size() > 0);
            mon_exp   = mon_have ? sb_q[0] : 8'h00;
            mon_rx    = 8'h00;
            mon_shape = 1'b1;
            mon_abort = 1'b0;
            for (int k = 0; k < 10 * mon_p; k++) begin
                if (k > 0) @(negedge clk);
                if (reset) begin
                    mon_abort = 1'b1;
                    break;
                end
                mon_bit = k / mon_p;
                if (mon_bit == 0)      mon_lvl = 1'b0;
                else if (mon_bit == 9) mon_lvl = 1'b1;
                else                   mon_lvl = mon_exp[mon_bit-1];
                if (txd !== mon_lvl) mon_shape = 1'b0;
                if (mon_bit >= 1 && mon_bit <= 8 && (k % mon_p) == mon_p / 2)
                    mon_rx[mon_bit-1] = txd;
            end
            if (!mon_abort) begin
                if (!mon_have) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_frame actual=%0h required=none at cycle %0d",
                             mon_rx, mon_start);
                end else begin
                    void'(sb_q.pop_front());
                    checkOutput("frame_byte", mon_rx, mon_exp);
                    checkOutput("frame_shape", mon_shape, 1'b1);
                end
                start_q.push_back(mon_start);
                frames_done++;
            end
        end
    end

    initial begin
        logic [7:0] v;
        int         f0;
        int         n0;
        int         w0;
        int         bad_k;
        logic [7:0] exp_status;

        reset      = 1'b1;
        sel        = 1'b0;
        addr       = 2'd0;
        data_in    = 8'h00;
        data_rw_n  = 1'b1;
        bit_period = 16;

        // 1. Reset values
        tick(2);
        reset = 1'b0;
        readReg(2'd1, v); checkOutput("rst_status", v, 8'h02);
        readReg(2'd2, v); checkOutput("rst_divlo", v, 8'h0F);
        readReg(2'd3, v); checkOutput("rst_divhi", v, 8'h00);
        readReg(2'd0, v); checkOutput("rst_txdata_read", v, 8'h00);
        checkOutput("rst_txd", txd, 1'b1);
        checkOutput("rst_irq", irq, 1'b0);
        checkOutput("unselected_data_out", data_out, 8'h00);

        // 2. Single byte 8'hA5 at DIV=3: 40-cycle frame, busy exactly while framing
        applyStimulus(2'd2, 8'h03);
        applyStimulus(2'd3, 8'h00);
        bit_period = 4;
        readReg(2'd2, v); checkOutput("divlo_readback", v, 8'h03);
        f0 = frames_done;
        sb_q.push_back(8'hA5);
        applyStimulus(2'd0, 8'hA5);
        w0    = last_wr_cyc;
        bad_k = -1;
        for (int k = 0; k < 45; k++) begin
            readReg(2'd1, v);
            if (k == 0)      exp_status = 8'h00;
            else if (k <= 40) exp_status = 8'h06;
            else             exp_status = 8'h02;
            if (v !== exp_status && bad_k < 0) bad_k = k;
        end
        checkOutput("busy_window_first_bad_sample", bad_k, -1);
        checkOutput("single_frame_count", frames_done, f0 + 1);
        if (start_q.size() > 0)
            checkOutput("single_start_latency", start_q[start_q.size()-1], w0 + 1);

        // 3. Overflow at DIV=15: five accepted, sixth dropped, ovf clears
        applyStimulus(2'd2, 8'h0F);
        bit_period = 16;
        f0 = frames_done;
        sb_q.push_back(8'h11); applyStimulus(2'd0, 8'h11);
        sb_q.push_back(8'h22); applyStimulus(2'd0, 8'h22);
        sb_q.push_back(8'h33); applyStimulus(2'd0, 8'h33);
        sb_q.push_back(8'h44); applyStimulus(2'd0, 8'h44);
        sb_q.push_back(8'h55); applyStimulus(2'd0, 8'h55);
        applyStimulus(2'd0, 8'h66);
        readReg(2'd1, v); checkOutput("ovf_status_full", v, 8'h0D);
        applyStimulus(2'd1, 8'h08);
        readReg(2'd1, v); checkOutput("ovf_cleared", v, 8'h05);
        waitFrames(f0 + 5, 1200, "ovf_frames_sent");
        tick(40);
        checkOutput("ovf_no_extra_frame", frames_done, f0 + 5);
        readReg(2'd1, v); checkOutput("ovf_idle_status", v, 8'h02);

        // 4. Back-to-back 8'h00, 8'hFF at DIV=0: no idle gap between frames
        applyStimulus(2'd2, 8'h00);
        bit_period = 1;
        f0 = frames_done;
        n0 = start_q.size();
        sb_q.push_back(8'h00); applyStimulus(2'd0, 8'h00);
        w0 = last_wr_cyc;
        sb_q.push_back(8'hFF); applyStimulus(2'd0, 8'hFF);
        waitFrames(f0 + 2, 60, "b2b_frames_sent");
        if (start_q.size() >= n0 + 2) begin
            checkOutput("b2b_first_start", start_q[n0], w0 + 1);
            checkOutput("b2b_gap", start_q[n0+1] - start_q[n0], 10);
        end

        // 5. Interrupt: ie set, drops after push, returns after pop
        applyStimulus(2'd1, 8'h80);
        checkOutput("irq_same_cycle_as_ie", irq, 1'b0);
        tick(1);
        checkOutput("irq_after_ie", irq, 1'b1);
        f0 = frames_done;
        sb_q.push_back(8'h3C);
        applyStimulus(2'd0, 8'h3C);
        checkOutput("irq_at_push", irq, 1'b1);
        tick(1);
        checkOutput("irq_after_push", irq, 1'b0);
        tick(1);
        checkOutput("irq_after_pop", irq, 1'b1);
        readReg(2'd1, v); checkOutput("irq_busy_status", v, 8'h86);
        waitFrames(f0 + 1, 60, "irq_frame_sent");

        // 6. Reset during DATA bit 3 of 8'hF7 with two bytes queued
        applyStimulus(2'd2, 8'h0F);
        bit_period = 16;
        sb_q.push_back(8'hF7);
        applyStimulus(2'd0, 8'hF7);
        applyStimulus(2'd0, 8'h12);
        applyStimulus(2'd0, 8'h34);
        tick(68);
        checkOutput("midframe_bit3_low", txd, 1'b0);
        reset = 1'b1;
        tick(1);
        checkOutput("midframe_reset_txd", txd, 1'b1);
        tick(1);
        reset = 1'b0;
        sb_q.delete();
        readReg(2'd1, v); checkOutput("post_reset_status", v, 8'h02);
        checkOutput("post_reset_irq", irq, 1'b0);
        f0 = frames_done;
        tick(400);
        checkOutput("post_reset_no_frames", frames_done, f0);
        checkOutput("post_reset_txd_idle", txd, 1'b1);

        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
